// File: rtl/tl_buffer_param_if.sv
// TileLink-UL A/D channel bundle; master drives A and accepts D, slave the reverse.
interface tl_buffer_param_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 4,
    parameter int SIZE_W = 4
);
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [SIZE_W-1:0]     a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [6:0]            a_user;
    logic [DATA_W/8-1:0]   a_mask;
    logic [DATA_W-1:0]     a_data;
    logic                  a_corrupt;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [SIZE_W-1:0]     d_size;
    logic [SRC_W-1:0]      d_source;
    logic                  d_sink;
    logic                  d_denied;
    logic [DATA_W-1:0]     d_data;
    logic                  d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_user, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink,
               d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_user, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink,
               d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_buffer_param.sv
// Parametrised TL-UL A/D buffer with occupancy, outstanding limiter and underflow flag.
// Latency: 1 cycle per queue (0 with FLOW on empty or DEPTH=0); ready drops when full or at MAX_OUT.

module tl_buffer_param_q #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int PIPE  = 0,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_vld,
    output logic          enq_rdy,
    input  logic [W-1:0]  enq_dat,
    output logic          deq_vld,
    input  logic          deq_rdy,
    output logic [W-1:0]  deq_dat,
    output logic [CW-1:0] cnt
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign deq_vld = enq_vld;
            assign enq_rdy = deq_rdy;
            assign deq_dat = enq_dat;
            assign cnt     = '0;
        end else begin : g_q
            localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

            logic [W-1:0]  r_mem [DEPTH];
            logic [PW-1:0] r_wptr;
            logic [PW-1:0] r_rptr;
            logic [CW-1:0] r_cnt;
            logic          w_empty;
            logic          w_full;
            logic          w_bypass;
            logic          w_push;
            logic          w_pop;

            function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
                return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
            endfunction

            assign w_empty  = (r_cnt == '0);
            assign w_full   = (r_cnt == CW'(DEPTH));
            assign enq_rdy  = !w_full || ((PIPE != 0) && deq_rdy);
            assign deq_vld  = !w_empty || ((FLOW != 0) && enq_vld);
            assign deq_dat  = ((FLOW != 0) && w_empty) ? enq_dat : r_mem[r_rptr];
            // A flow-through beat never touches storage or the count.
            assign w_bypass = (FLOW != 0) && w_empty && enq_vld && deq_rdy;
            assign w_push   = enq_vld && enq_rdy && !w_bypass;
            assign w_pop    = deq_vld && deq_rdy && !w_bypass;
            assign cnt      = r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push) r_wptr <= nxt(r_wptr);
                    if (w_pop)  r_rptr <= nxt(r_rptr);
                    if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
                    else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) r_mem[r_wptr] <= enq_dat;
            end
        end
    endgenerate
endmodule

module tl_buffer_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 4,
    parameter int SIZE_W  = 4,
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int A_FLOW  = 0,
    parameter int D_FLOW  = 0,
    parameter int A_PIPE  = 0,
    parameter int D_PIPE  = 0,
    parameter int MAX_OUT = 4,
    localparam int AC_W   = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int DC_W   = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    tl_buffer_param_if.slave  in_tl,
    tl_buffer_param_if.master out_tl,
    output logic [AC_W-1:0]   a_count,
    output logic [DC_W-1:0]   d_count,
    output logic [7:0]        outstanding,
    output logic              err_underflow
);
    localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + 7 + DATA_W/8 + DATA_W + 1;
    localparam int D_W = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W + 1;
    localparam int LB  = $clog2(DATA_W / 8);
    localparam int BW  = 16;

    logic [A_W-1:0] w_a_enq_dat;
    logic [A_W-1:0] w_a_deq_dat;
    logic [D_W-1:0] w_d_enq_dat;
    logic [D_W-1:0] w_d_deq_dat;
    logic           w_a_enq_vld;
    logic           w_a_enq_rdy;
    logic           w_hold;
    logic           w_a_fire;
    logic           w_d_fire;
    logic           w_a_last;
    logic           w_d_last;
    logic [BW-1:0]  r_a_beat;
    logic [BW-1:0]  r_d_beat;
    logic [7:0]     r_out;
    logic           r_err;

    function automatic logic [BW-1:0] beats_m1(input logic [SIZE_W-1:0] size, input logic has_data);
        if (has_data && (int'(size) > LB))
            return BW'((32'd1 << (int'(size) - LB)) - 32'd1);
        return '0;
    endfunction

    assign w_a_enq_dat = {in_tl.a_opcode, in_tl.a_param, in_tl.a_size, in_tl.a_source,
                          in_tl.a_address, in_tl.a_user, in_tl.a_mask, in_tl.a_data,
                          in_tl.a_corrupt};
    assign {out_tl.a_opcode, out_tl.a_param, out_tl.a_size, out_tl.a_source,
            out_tl.a_address, out_tl.a_user, out_tl.a_mask, out_tl.a_data,
            out_tl.a_corrupt} = w_a_deq_dat;

    assign w_d_enq_dat = {out_tl.d_opcode, out_tl.d_param, out_tl.d_size, out_tl.d_source,
                          out_tl.d_sink, out_tl.d_denied, out_tl.d_data, out_tl.d_corrupt};
    assign {in_tl.d_opcode, in_tl.d_param, in_tl.d_size, in_tl.d_source,
            in_tl.d_sink, in_tl.d_denied, in_tl.d_data, in_tl.d_corrupt} = w_d_deq_dat;

    // Only a new message's first beat can be held off; bursts always complete.
    assign w_hold         = (r_out == 8'(MAX_OUT)) && (r_a_beat == '0);
    assign w_a_enq_vld    = in_tl.a_valid && !w_hold;
    assign in_tl.a_ready  = w_a_enq_rdy && !w_hold;

    tl_buffer_param_q #(.W(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .CW(AC_W)) u_a_q (
        .clk     (clock),
        .rst     (reset),
        .enq_vld (w_a_enq_vld),
        .enq_rdy (w_a_enq_rdy),
        .enq_dat (w_a_enq_dat),
        .deq_vld (out_tl.a_valid),
        .deq_rdy (out_tl.a_ready),
        .deq_dat (w_a_deq_dat),
        .cnt     (a_count)
    );

    tl_buffer_param_q #(.W(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .CW(DC_W)) u_d_q (
        .clk     (clock),
        .rst     (reset),
        .enq_vld (out_tl.d_valid),
        .enq_rdy (out_tl.d_ready),
        .enq_dat (w_d_enq_dat),
        .deq_vld (in_tl.d_valid),
        .deq_rdy (in_tl.d_ready),
        .deq_dat (w_d_deq_dat),
        .cnt     (d_count)
    );

    assign w_a_fire = in_tl.a_valid && in_tl.a_ready;
    assign w_d_fire = in_tl.d_valid && in_tl.d_ready;
    assign w_a_last = (r_a_beat == beats_m1(in_tl.a_size, in_tl.a_opcode <= 3'd3));
    assign w_d_last = (r_d_beat == beats_m1(in_tl.d_size,
                                            (in_tl.d_opcode == 3'd1) || (in_tl.d_opcode == 3'd5)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_beat <= '0;
            r_d_beat <= '0;
        end else begin
            if (w_a_fire) r_a_beat <= w_a_last ? '0 : r_a_beat + 1'b1;
            if (w_d_fire) r_d_beat <= w_d_last ? '0 : r_d_beat + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_a_fire && w_a_last && !(w_d_fire && w_d_last)) begin
            r_out <= r_out + 8'd1;
        end else if (w_d_fire && w_d_last && !(w_a_fire && w_a_last)) begin
            if (r_out == '0) r_err <= 1'b1;
            else             r_out <= r_out - 8'd1;
        end
    end

    assign outstanding   = r_out;
    assign err_underflow = r_err;
endmodule
